// File: rtl/pps_disciplined_divider.sv
// 1 Hz local timebase from the system clock, disciplined to GPS PPS.
// Measures PPS intervals, aligns ticks to accepted edges, holds over on loss.
module pps_disciplined_divider #(
  parameter int WIDTH      = 28,
  parameter int NOMINAL    = 50000000,
  parameter int TOL        = 5000,
  parameter int MISS_LIMIT = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             pps_in,
  output logic             tick_out,
  output logic             pps_valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] phase,
  output logic             locked,
  output logic             holdover
);

  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] NOM_M   = WIDTH'(NOMINAL);
  localparam logic [WIDTH-1:0] TOL_M   = WIDTH'(TOL);
  localparam logic [WIDTH-1:0] TOL1_M  = WIDTH'(TOL + 1);
  localparam logic [WIDTH-1:0] HI_M    = WIDTH'(NOMINAL + TOL);
  localparam logic [WIDTH:0]   LO_W    = (WIDTH+1)'(NOMINAL - TOL);
  localparam logic [WIDTH:0]   HI_W    = (WIDTH+1)'(NOMINAL + TOL);
  localparam logic [MW-1:0]    LIMIT_M = MW'(MISS_LIMIT);
  localparam logic [MW-1:0]    MISS1_M = MW'(1);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED,
    HOLDOVER
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic             edge_q, edge_d;
  logic [WIDTH-1:0] meas_q, meas_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [1:0]       good_q, good_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic             first_q, first_d;
  logic             tick_q, tick_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             hold_q, hold_d;

  logic [WIDTH:0]   interval;
  logic [MW-1:0]    miss_inc;
  logic             pps_edge;
  logic             in_range;
  logic             early;
  logic             nat_tick;
  logic             timeout;
  logic             near_start;
  logic             near_end;

  always_comb begin
    sync1_d = pps_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    edge_d  = sync2_q & ~sync3_q;
  end

  assign pps_edge   = edge_q;
  assign interval   = {1'b0, meas_q} + {1'b0, ONE};
  assign in_range   = (interval >= LO_W) && (interval <= HI_W);
  assign early      = interval < LO_W;
  assign nat_tick   = phase_q == (period_q - ONE);
  assign timeout    = meas_q == HI_M;
  assign near_start = phase_q <= TOL_M;
  assign near_end   = phase_q >= (period_q - TOL1_M);
  assign miss_inc   = miss_q + MISS1_M;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + ONE;
    period_d = period_q;
    good_d   = good_q;
    miss_d   = miss_q;
    first_d  = first_q;
    tick_d   = 1'b0;
    valid_d  = 1'b0;
    if (pps_edge) begin
      meas_d = '0;
    end else if (&meas_q) begin
      meas_d = meas_q;
    end else begin
      meas_d = meas_q + ONE;
    end

    unique case (state_q)
      UNLOCKED: begin
        if (nat_tick) begin
          tick_d  = 1'b1;
          phase_d = '0;
        end
        if (pps_edge) begin
          if (!first_q) begin
            first_d = 1'b1;
          end else if (in_range) begin
            good_d   = good_q + 2'd1;
            period_d = interval[WIDTH-1:0];
            // second good interval: lock and realign to this edge
            if (good_q == 2'd1) begin
              state_d = LOCKED;
              tick_d  = 1'b1;
              valid_d = 1'b1;
              phase_d = '0;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (pps_edge && in_range) begin
          tick_d   = 1'b1;
          valid_d  = 1'b1;
          period_d = interval[WIDTH-1:0];
          phase_d  = '0;
        end else if (pps_edge && early) begin
          state_d = UNLOCKED;
          good_d  = '0;
          first_d = 1'b0;
        end else if (timeout) begin
          tick_d  = 1'b1;
          phase_d = '0;
          miss_d  = MISS1_M;
          state_d = HOLDOVER;
        end
      end
      HOLDOVER: begin
        if (pps_edge && (near_start || near_end)) begin
          // late-side edge supplies the tick; early-side one already had it
          tick_d  = near_end;
          valid_d = 1'b1;
          phase_d = '0;
          miss_d  = '0;
          state_d = LOCKED;
        end else if (nat_tick) begin
          tick_d  = 1'b1;
          phase_d = '0;
          miss_d  = miss_inc;
          if (miss_inc >= LIMIT_M) begin
            state_d = UNLOCKED;
            good_d  = '0;
            first_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = UNLOCKED;
      end
    endcase

    locked_d = state_d == LOCKED;
    hold_d   = state_d == HOLDOVER;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      edge_q   <= 1'b0;
      meas_q   <= '0;
      phase_q  <= '0;
      period_q <= NOM_M;
      good_q   <= '0;
      miss_q   <= '0;
      first_q  <= 1'b0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      edge_q   <= edge_d;
      meas_q   <= meas_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      first_q  <= first_d;
      tick_q   <= tick_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      hold_q   <= hold_d;
    end
  end

  assign tick_out  = tick_q;
  assign pps_valid = valid_q;
  assign period    = period_q;
  assign phase     = phase_q;
  assign locked    = locked_q;
  assign holdover  = hold_q;

endmodule

// File: tb/tb_pps_disciplined_divider.sv
// Directed bench for pps_disciplined_divider.
// WIDTH=8, NOMINAL=20, TOL=2, MISS_LIMIT=3.
module tb_pps_disciplined_divider;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic         pps_in = 1'b0;
  logic         tick_out;
  logic         pps_valid;
  logic [W-1:0] period;
  logic [W-1:0] phase;
  logic         locked;
  logic         holdover;

  int checks = 0;
  int failures = 0;

  pps_disciplined_divider #(
    .WIDTH(W),
    .NOMINAL(20),
    .TOL(2),
    .MISS_LIMIT(3)
  ) dut (
    .clock(clock),
    .rst(rst),
    .pps_in(pps_in),
    .tick_out(tick_out),
    .pps_valid(pps_valid),
    .period(period),
    .phase(phase),
    .locked(locked),
    .holdover(holdover)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // reset, then free-run at period 20
    rst = 1'b1;
    pps_in = 1'b0;
    go(3);
    chk("rst_tick", 32'(tick_out), 0);
    chk("rst_valid", 32'(pps_valid), 0);
    chk("rst_period", 32'(period), 20);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_hold", 32'(holdover), 0);
    rst = 1'b0;
    go(19);
    chk("fr_tick19", 32'(tick_out), 0);
    go(1);
    chk("fr_tick20", 32'(tick_out), 1);
    chk("fr_phase20", 32'(phase), 0);
    chk("fr_locked20", 32'(locked), 0);
    go(19);
    chk("fr_tick39", 32'(tick_out), 0);
    go(1);
    chk("fr_tick40", 32'(tick_out), 1);
    go(20);
    chk("fr_tick60", 32'(tick_out), 1);
    chk("fr_locked60", 32'(locked), 0);

    // lock acquisition: edges every 20 cycles
    pps_in = 1'b1; go(4); pps_in = 1'b0; go(16);
    pps_in = 1'b1; go(4);
    chk("acq_e2_locked", 32'(locked), 0);
    pps_in = 1'b0; go(16);
    pps_in = 1'b1; go(4);
    chk("acq_tick", 32'(tick_out), 1);
    chk("acq_valid", 32'(pps_valid), 1);
    chk("acq_locked", 32'(locked), 1);
    chk("acq_period", 32'(period), 20);
    chk("acq_phase", 32'(phase), 0);
    pps_in = 1'b0; go(16);
    // edge-driven tick at latency 3 after sampling; held high 12 cycles
    pps_in = 1'b1; go(3);
    chk("lk_tick_pre", 32'(tick_out), 0);
    chk("lk_phase19", 32'(phase), 19);
    go(1);
    chk("lk_tick", 32'(tick_out), 1);
    chk("lk_valid", 32'(pps_valid), 1);
    go(8); pps_in = 1'b0; go(9);

    // interval 21 tracked
    pps_in = 1'b1; go(4);
    chk("trk_tick", 32'(tick_out), 1);
    chk("trk_period", 32'(period), 21);
    chk("trk_locked", 32'(locked), 1);
    pps_in = 1'b0; go(13);
    // interval 17 is early
    pps_in = 1'b1; go(4);
    chk("early_tick", 32'(tick_out), 0);
    chk("early_valid", 32'(pps_valid), 0);
    chk("early_locked", 32'(locked), 0);
    chk("early_hold", 32'(holdover), 0);
    pps_in = 1'b0; go(16);

    // relock: start edge, one good, lock
    pps_in = 1'b1; go(4); pps_in = 1'b0; go(16);
    pps_in = 1'b1; go(4); pps_in = 1'b0; go(16);
    pps_in = 1'b1; go(4);
    chk("relk_locked", 32'(locked), 1);
    chk("relk_tick", 32'(tick_out), 1);
    chk("relk_period", 32'(period), 20);
    pps_in = 1'b0;

    // PPS lost: timeout 23 after last tick, then two holdover ticks
    go(22);
    chk("to_tick22", 32'(tick_out), 0);
    chk("to_locked22", 32'(locked), 1);
    go(1);
    chk("to_tick23", 32'(tick_out), 1);
    chk("to_hold23", 32'(holdover), 1);
    chk("to_locked23", 32'(locked), 0);
    chk("to_phase23", 32'(phase), 0);
    go(19);
    chk("ho_tick19", 32'(tick_out), 0);
    go(1);
    chk("ho_tick20", 32'(tick_out), 1);
    chk("ho_hold20", 32'(holdover), 1);
    go(20);
    chk("ho_tick40", 32'(tick_out), 1);
    chk("ho_hold40", 32'(holdover), 0);
    chk("ho_locked40", 32'(locked), 0);

    // relock again, then enter holdover
    go(1);
    pps_in = 1'b1; go(15); pps_in = 1'b0; go(5);
    pps_in = 1'b1; go(4); pps_in = 1'b0; go(16);
    pps_in = 1'b1; go(4);
    chk("rl2_locked", 32'(locked), 1);
    chk("rl2_tick", 32'(tick_out), 1);
    pps_in = 1'b0;
    go(23);
    chk("ho2_tick", 32'(tick_out), 1);
    chk("ho2_hold", 32'(holdover), 1);

    // edge at phase 10 is ignored
    go(7);
    pps_in = 1'b1; go(4);
    chk("ph10_valid", 32'(pps_valid), 0);
    chk("ph10_tick", 32'(tick_out), 0);
    chk("ph10_hold", 32'(holdover), 1);
    pps_in = 1'b0; go(9);
    chk("ph10_nat_tick", 32'(tick_out), 1);
    chk("ph10_nat_hold", 32'(holdover), 1);

    // edge at phase 19 merges with the natural tick
    go(16);
    pps_in = 1'b1; go(3);
    chk("ph19_pre_tick", 32'(tick_out), 0);
    go(1);
    chk("ph19_tick", 32'(tick_out), 1);
    chk("ph19_valid", 32'(pps_valid), 1);
    chk("ph19_locked", 32'(locked), 1);
    chk("ph19_hold", 32'(holdover), 0);
    chk("ph19_period", 32'(period), 20);
    go(1);
    chk("ph19_single", 32'(tick_out), 0);
    chk("ph19_valid_end", 32'(pps_valid), 0);
    pps_in = 1'b0;

    // holdover again, then edge at phase 1
    go(22);
    chk("ho3_tick", 32'(tick_out), 1);
    chk("ho3_hold", 32'(holdover), 1);
    go(18);
    pps_in = 1'b1; go(2);
    chk("ph1_nat_tick", 32'(tick_out), 1);
    chk("ph1_nat_hold", 32'(holdover), 1);
    go(2);
    chk("ph1_valid", 32'(pps_valid), 1);
    chk("ph1_tick", 32'(tick_out), 0);
    chk("ph1_locked", 32'(locked), 1);
    chk("ph1_period", 32'(period), 20);
    pps_in = 1'b0;

    // reset coincident with an in-range edge
    go(16);
    pps_in = 1'b1; go(3);
    rst = 1'b1;
    pps_in = 1'b0;
    go(1);
    chk("mrst_tick", 32'(tick_out), 0);
    chk("mrst_valid", 32'(pps_valid), 0);
    chk("mrst_locked", 32'(locked), 0);
    chk("mrst_hold", 32'(holdover), 0);
    chk("mrst_period", 32'(period), 20);
    chk("mrst_phase", 32'(phase), 0);
    rst = 1'b0;
    go(19);
    chk("mrst_tick19", 32'(tick_out), 0);
    go(1);
    chk("mrst_tick20", 32'(tick_out), 1);
    chk("mrst_locked20", 32'(locked), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pps_disciplined_divider.md
# pps_disciplined_divider

Parametrised successor to the free-running cycle counter: it derives the 1 Hz local timebase from the system clock and disciplines it to the GPS PPS input. It measures the clock-cycle interval between PPS edges, aligns the local tick to accepted edges, and free-runs on the last good period when PPS is lost (holdover). It sits between the GPS receiver PPS pin and the time-of-day/display logic, which consumes `tick_out`.

## Interface
- WIDTH, 28: width of all cycle counters and `period`/`phase`.
- NOMINAL, 50000000: nominal clock cycles per second; the reset value of `period`.
- TOL, 5000: accepted deviation in cycles, ± from NOMINAL (or from the expected tick in holdover).
- MISS_LIMIT, 3: consecutive missed seconds in holdover before dropping to unlocked.

- clock  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- pps_in  in  1  raw GPS PPS; asynchronous to `clock`.
- tick_out  out  1  one-cycle 1 Hz local tick.
- pps_valid  out  1  one-cycle pulse on each accepted PPS edge.
- period  out  WIDTH  last accepted interval in cycles.
- phase  out  WIDTH  cycles since the last tick.
- locked  out  1  state == LOCKED.
- holdover  out  1  state == HOLDOVER.

## Operation
- Synchroniser: two flops on `pps_in`, then rising-edge detect giving `pps_edge`.
- meas counter:
  - Cleared to 0 on each `pps_edge`; otherwise increments, saturating at all-ones.
  - Interval at an edge = meas+1.
  - In range iff NOMINAL-TOL ≤ interval ≤ NOMINAL+TOL.
- Local divider:
  - `phase` increments each cycle.
  - Natural tick when phase == period-1; the tick cycle sets phase to 0.
- UNLOCKED (reset state):
  - Natural ticks only.
  - First edge after reset or after entry to UNLOCKED only starts measurement.
  - An in-range interval increments good_cnt and loads `period`; an out-of-range interval clears good_cnt.
  - good_cnt == 2 → LOCKED. Phase is realigned to that edge (tick_out=1, phase←0).
- LOCKED:
  - Ticks come only from edges; natural wrap is suppressed.
  - In-range edge: tick_out=1, pps_valid=1, period←interval, phase←0.
  - Early edge (interval < NOMINAL-TOL): no tick → UNLOCKED, good_cnt←0.
  - Timeout (meas == NOMINAL+TOL with no edge): tick_out=1, phase←0, miss_cnt←1 → HOLDOVER.
- HOLDOVER:
  - Natural ticks with the frozen `period`.
  - Each natural tick not preceded by an accepted edge since the previous tick increments miss_cnt.
  - miss_cnt reaching MISS_LIMIT on a tick → UNLOCKED. That tick is still emitted.
  - Edge accepted iff phase ≤ TOL or phase ≥ period-1-TOL. On an accepted edge: pps_valid=1, phase←0, miss_cnt←0 → LOCKED, `period` unchanged.
    - If phase ≥ period-1-TOL: tick_out=1. A natural tick in the same cycle merges into one pulse.
    - If phase ≤ TOL: no tick, since the natural tick already fired.
  - Non-accepted edge: ignored apart from clearing meas.
- rst is honoured in any state. It overrides everything, including an edge in the same cycle, and clears synchroniser flops, good_cnt and miss_cnt.

## Timing
- Reset values: tick_out=0, pps_valid=0, period=NOMINAL, phase=0, locked=0, holdover=0, state UNLOCKED.
- All outputs are registered.
- Latency: `pps_in` first sampled high at clock edge k → edge-driven tick_out/pps_valid high in cycle k+3.
- Tick spacing is exactly `period` cycles when free-running.
- Edges to consecutive accepted edges are N cycles apart → interval = N.
- State flags update in the same cycle as the tick/pps_valid that caused the transition.
- A PPS held high for many cycles produces exactly one edge.

## Test plan
Bench parameters: WIDTH=8, NOMINAL=20, TOL=2, MISS_LIMIT=3.

- **Reset and free-run:** rst 3 cycles, no PPS → all reset values; tick_out at cycles 20, 40, 60 after release; locked=0 throughout.
- **Lock acquisition:** PPS edges every 20 cycles → third edge gives locked=1, tick_out and pps_valid coincident, period=20; subsequent ticks follow edges at latency 3.
- **Period tracking / early edge:** while locked, interval 21 → period=21, still locked. Then interval 17 → no tick, locked=0, holdover=0.
- **Holdover and loss:** stop PPS while locked → tick and holdover=1 at 23 cycles after the last edge. Ticks then follow at +20 and +40; the second of these sets holdover=0 and locked=0.
- **Reacquire from holdover:**
  - Edge arriving at phase 19 → single tick, pps_valid=1, locked=1, period unchanged.
  - Edge at phase 1 → pps_valid=1, no extra tick.
  - Edge at phase 10 → ignored, remains in holdover.
- **Reset mid-operation:** rst asserted while locked, coincident with a PPS edge → next cycle all reset values, no tick, state UNLOCKED.
